// File: rtl/accum_feeder.sv
// accum_feeder: FIFO-buffered, rate-paced operand feeder for the
// 3-cycle enable/value accumulator.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   in_valid/in_data    upstream word, accepted when in_ready
//   in_ready            FIFO not full (depends on level only)
//   pause               blocks new issues while high
//   enable              one-cycle issue pulse
//   value               registered operand, held between issues
//   level               FIFO occupancy
//   issued_count        wrapping count of issued words
module accum_feeder #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int ISSUE_PERIOD = 3,
  parameter int CNT_W        = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  input  logic                         pause,
  output logic                         enable,
  output logic [WIDTH-1:0]             value,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNT_W-1:0]             issued_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int HW = $clog2(ISSUE_PERIOD);

  localparam logic IDLE = 1'b0;
  localparam logic HOLD = 1'b1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             enable_q, enable_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic push;
  logic issue;

  // No look-ahead on a same-cycle pop: a full FIFO refuses input.
  assign in_ready = (level_q != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign issue    = (state_q == IDLE) && (level_q != '0) && !pause;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    enable_d = 1'b0;
    value_d  = value_q;
    cnt_d    = cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (issue) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          value_d  = mem_q[rd_ptr_q];
          enable_d = 1'b1;
          hold_d   = HW'(ISSUE_PERIOD-2);
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // Counter runs from ISSUE_PERIOD-2 down to 0, so HOLD spans
        // ISSUE_PERIOD-1 cycles including the enable cycle.
        if (hold_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    unique case ({push, issue})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      enable_q <= 1'b0;
      value_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      enable_q <= enable_d;
      value_q  <= value_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: clearing the pointers discards contents.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign enable       = enable_q;
  assign value        = value_q;
  assign level        = level_q;
  assign issued_count = cnt_q;

endmodule

// File: tb/tb_accum_feeder.sv
// tb_accum_feeder: directed + randomized checks of accum_feeder
// against a queue-based reference model.
module tb_accum_feeder;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int P  = 3;
  localparam int CW = 16;
  localparam int LW = $clog2(D+1);

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          pause;
  logic          enable;
  logic [W-1:0]  value;
  logic [LW-1:0] level;
  logic [CW-1:0] issued_count;

  accum_feeder #(
    .WIDTH(W), .DEPTH(D), .ISSUE_PERIOD(P), .CNT_W(CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .pause(pause),
    .enable(enable),
    .value(value),
    .level(level),
    .issued_count(issued_count)
  );

  always #5 CLK = ~CLK;

  logic [W-1:0]  q [$];
  logic [W-1:0]  m_value;
  logic          m_enable;
  logic [CW-1:0] m_cnt;
  int            cyc;
  int            last_iss;
  int            tests;
  int            fails;
  int            acc_sum;
  int            en_seen;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by the stated rules,
  // then compare all outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic p, input logic r);
    bit push;
    bit iss;
    in_valid = v;
    in_data  = d;
    pause    = p;
    RST      = r;
    @(posedge CLK);
    cyc++;
    if (r) begin
      q.delete();
      m_value  = '0;
      m_enable = 1'b0;
      m_cnt    = '0;
      last_iss = -1000;
    end else begin
      push = v && (q.size() != D);
      iss  = (q.size() != 0) && !p && (cyc - last_iss >= P);
      m_enable = iss;
      if (iss) begin
        m_value  = q.pop_front();
        m_cnt    = m_cnt + 1'b1;
        last_iss = cyc;
      end
      if (push) q.push_back(d);
    end
    #1;
    if (enable === 1'b1) begin
      acc_sum += int'(value);
      en_seen++;
    end
    chk("enable", 64'(enable), 64'(m_enable));
    chk("value", 64'(value), 64'(m_value));
    chk("level", 64'(level), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() != D));
    chk("issued_count", 64'(issued_count), 64'(m_cnt));
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    last_iss = -1000;
    acc_sum  = 0;
    en_seen  = 0;
    m_value  = '0;
    m_enable = 1'b0;
    m_cnt    = '0;
    RST      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    pause    = 1'b0;

    // Reset for two cycles, then release.
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    chk("rst_value", 64'(value), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Single word: level 1, pulse on the second edge, value held.
    step(1, 32'h5, 0, 0);
    chk("single_level", 64'(level), 64'd1);
    chk("single_noen", 64'(enable), 64'd0);
    step(0, '0, 0, 0);
    chk("single_en", 64'(enable), 64'd1);
    chk("single_val", 64'(value), 64'h5);
    for (int k = 0; k < 5; k++) step(0, '0, 0, 0);
    chk("single_hold", 64'(value), 64'h5);
    chk("single_cnt", 64'(issued_count), 64'd1);

    // Burst of 8 under pause, 9th refused, then release.
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) chk("burst_full", 64'(in_ready), 64'd0);
      step(1, W'(i), 1, 0);
    end
    chk("burst_level", 64'(level), 64'd8);
    acc_sum = 0;
    en_seen = 0;
    for (int k = 0; k < 30; k++) step(0, '0, 0, 0);
    chk("burst_sum", 64'(acc_sum), 64'd36);
    chk("burst_pulses", 64'(en_seen), 64'd8);
    chk("burst_cnt", 64'(issued_count), 64'd9);

    // Continuous stream across pointer wrap.
    en_seen = 0;
    for (int k = 0; k < 70; k++) step(1, $urandom, 0, 0);
    for (int k = 0; k < 30; k++) step(0, '0, 0, 0);
    chk("stream_issues_gt16", 64'(en_seen > 16), 64'd1);

    // Pause raised in the enable cycle.
    for (int k = 0; k < 3; k++) step(1, $urandom, 1, 0);
    step(0, '0, 0, 0);
    chk("pause_en", 64'(enable), 64'd1);
    en_seen = 0;
    for (int k = 0; k < 8; k++) step(0, '0, 1, 0);
    chk("pause_block", 64'(en_seen), 64'd0);
    step(0, '0, 0, 0);
    chk("pause_resume", 64'(enable), 64'd1);
    for (int k = 0; k < 10; k++) step(0, '0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 5) == 0), 0);
    end
    for (int k = 0; k < 30; k++) step(0, '0, 0, 0);

    // Reset mid-HOLD with three words still buffered.
    for (int k = 0; k < 4; k++) step(1, $urandom, 1, 0);
    step(0, '0, 0, 0);
    chk("rh_en", 64'(enable), 64'd1);
    chk("rh_level", 64'(level), 64'd3);
    step(0, '0, 0, 1);
    chk("rh_value", 64'(value), 64'd0);
    chk("rh_cnt", 64'(issued_count), 64'd0);
    en_seen = 0;
    for (int k = 0; k < 15; k++) step(0, '0, 0, 0);
    chk("rh_no_replay", 64'(en_seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
